// File: rtl/usart_pkg.sv
// Shared definitions for the USART transmitter: FSM state encoding,
// default bit timing and a parity helper.
package usart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic parity_of(input logic [7:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/usart_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Writes when full and reads when empty are ignored.
module usart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign full    = (count == (AW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/usart_tx.sv
// Buffered asynchronous serial transmitter: start bit, 8 data bits LSB
// first, optional parity, 1 or 2 stop bits; frames run back to back.
module usart_tx
   import usart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic [2:0] state_dbg
);

   localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic           PAR_ODD   = (PARITY_ODD != 0);

   state_t        state, state_nxt;
   logic [BW-1:0] baud_cnt, baud_nxt;
   logic [2:0]    bit_idx, idx_nxt;
   logic [7:0]    shift_reg, shift_nxt;
   logic          par_reg, par_nxt;
   logic          tx_nxt;
   logic          bit_end;
   logic          push, pop;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_data;

   assign push      = tx_valid && !fifo_full;
   assign tx_ready  = !fifo_full;
   assign busy      = (state != IDLE) || !fifo_empty;
   assign state_dbg = state;
   assign bit_end   = (baud_cnt == BAUD_LAST);

   usart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_data (tx_data),
      .rd_en   (pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         tx        <= 1'b1;
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_nxt;
         bit_idx   <= idx_nxt;
         shift_reg <= shift_nxt;
         par_reg   <= par_nxt;
         tx        <= tx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      baud_nxt  = bit_end ? '0 : baud_cnt + 1'b1;
      idx_nxt   = bit_idx;
      shift_nxt = shift_reg;
      par_nxt   = par_reg;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            baud_nxt = '0;
            idx_nxt  = '0;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_nxt = fifo_data;
               par_nxt   = parity_of(fifo_data, PAR_ODD);
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end) begin
               idx_nxt   = bit_idx + 3'd1;
               shift_nxt = {1'b0, shift_reg[7:1]};
               if (bit_idx == 3'd7) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (bit_end) begin
               idx_nxt = bit_idx + 3'd1;
               // Last stop bit: chain straight into the next frame if one is waiting.
               if (bit_idx == STOP_LAST) begin
                  idx_nxt = '0;
                  if (!fifo_empty) begin
                     pop       = 1'b1;
                     shift_nxt = fifo_data;
                     par_nxt   = parity_of(fifo_data, PAR_ODD);
                     state_nxt = START;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            baud_nxt  = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   // Line level is chosen from the next state so tx is a clean register.
   always_comb begin
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
         PARITY:  tx_nxt = par_nxt;
         default: tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_usart_tx.sv
// Bench for usart_tx: four instances (8N1, 8E1, 8O1, 8N2) checked cycle by
// cycle against a frame model built from the serial framing rules.
module tb_usart_tx;
   import usart_pkg::*;

   localparam int CPB = 434;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [3:0]      vld = '0;
   logic [7:0]      dat [4];
   logic [3:0]      rdy_w;
   logic [3:0]      tx_w;
   logic [3:0]      busy_w;
   logic [3:0][2:0] st_w;

   int         checks = 0;
   int         failures = 0;
   int         acc_cnt = 0;
   logic [7:0] exp_q [$];
   logic [7:0] push_q [$];

   always #5 clk = ~clk;

   usart_tx #(.CLKS_PER_BIT(CPB)) u0 (
      .clk(clk), .reset(reset), .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy_w[0]),
      .tx(tx_w[0]), .busy(busy_w[0]), .state_dbg(st_w[0]));
   usart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
      .clk(clk), .reset(reset), .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy_w[1]),
      .tx(tx_w[1]), .busy(busy_w[1]), .state_dbg(st_w[1]));
   usart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
      .clk(clk), .reset(reset), .tx_data(dat[2]), .tx_valid(vld[2]), .tx_ready(rdy_w[2]),
      .tx(tx_w[2]), .busy(busy_w[2]), .state_dbg(st_w[2]));
   usart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u3 (
      .clk(clk), .reset(reset), .tx_data(dat[3]), .tx_valid(vld[3]), .tx_ready(rdy_w[3]),
      .tx(tx_w[3]), .busy(busy_w[3]), .state_dbg(st_w[3]));

   function automatic int cfg_par_en(input int k);
      return (k == 1 || k == 2) ? 1 : 0;
   endfunction

   function automatic int cfg_par_odd(input int k);
      return (k == 2) ? 1 : 0;
   endfunction

   function automatic int cfg_stop(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   // Expected line level for bit position pos of a frame carrying byte b.
   function automatic logic model_bit(input logic [7:0] b, input int pos, input int k);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return b[pos-1];
      if (pos == 9 && cfg_par_en(k) == 1) return (^b) ^ (cfg_par_odd(k) == 1);
      return 1'b1;
   endfunction

   // Drive every byte of push_q into instance k, holding valid between bytes.
   task automatic push_seq(input int k);
      int guard;
      while (push_q.size() > 0) begin
         @(negedge clk);
         vld[k] = 1'b1;
         dat[k] = push_q[0];
         guard = 0;
         while (rdy_w[k] !== 1'b1 && guard < 20000) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20000) begin
            checks++;
            failures++;
            $display("FAIL push_timeout inst=%0d tx_ready=%b expected 1 within 20000 cycles", k, rdy_w[k]);
            vld[k] = 1'b0;
            push_q.delete();
            return;
         end
         @(posedge clk);
         void'(push_q.pop_front());
         acc_cnt++;
      end
      @(negedge clk);
      vld[k] = 1'b0;
   endtask

   // Wait for the first start bit, then check n contiguous frames from exp_q
   // cycle by cycle, then the idle line and busy right after the last frame.
   task automatic check_stream(input int k, input int n);
      int guard;
      int nbits;
      logic [7:0] b;
      logic e, bad, got;
      guard = 0;
      @(negedge clk);
      while (tx_w[k] !== 1'b0 && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 20000) begin
         failures++;
         $display("FAIL start_timeout inst=%0d tx=%b expected 0 within 20000 cycles", k, tx_w[k]);
         return;
      end
      nbits = 9 + cfg_par_en(k) + cfg_stop(k);
      for (int f = 0; f < n; f++) begin
         b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
         for (int pos = 0; pos < nbits; pos++) begin
            e = model_bit(b, pos, k);
            bad = 1'b0;
            got = e;
            for (int c = 0; c < CPB; c++) begin
               if (tx_w[k] !== e && !bad) begin
                  bad = 1'b1;
                  got = tx_w[k];
               end
               @(negedge clk);
            end
            checks++;
            if (bad) begin
               failures++;
               $display("FAIL frame_bit inst=%0d frame=%0d byte=%02h pos=%0d tx=%b expected %b",
                        k, f, b, pos, got, e);
            end
         end
      end
      checks++;
      if (busy_w[k] !== 1'b0 || tx_w[k] !== 1'b1) begin
         failures++;
         $display("FAIL idle_after_frames inst=%0d busy=%b tx=%b expected busy=0 tx=1", k, busy_w[k], tx_w[k]);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (tx_w[k] !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx inst=%0d got=%b expected 1", k, tx_w[k]);
         end
         checks++;
         if (busy_w[k] !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy inst=%0d got=%b expected 0", k, busy_w[k]);
         end
         checks++;
         if (rdy_w[k] !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready inst=%0d got=%b expected 1", k, rdy_w[k]);
         end
         checks++;
         if (st_w[k] !== 3'(IDLE)) begin
            failures++;
            $display("FAIL reset_state inst=%0d got=%0d expected %0d", k, st_w[k], 3'(IDLE));
         end
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      push_q = '{8'h0A};
      exp_q  = '{8'h0A};
      fork
         begin
            push_seq(0);
            checks++;
            if (busy_w[0] !== 1'b1) begin
               failures++;
               $display("FAIL single_busy got=%b expected 1", busy_w[0]);
            end
         end
         check_stream(0, 1);
      join
   endtask

   task automatic test_back_to_back();
      push_q = '{8'h55, 8'hAA};
      exp_q  = '{8'h55, 8'hAA};
      fork
         push_seq(0);
         check_stream(0, 2);
      join
   endtask

   task automatic test_fill();
      logic [7:0] bytes [6];
      logic [7:0] v;
      logic dup;
      for (int i = 0; i < 6; i++) begin
         do begin
            v = 8'($urandom_range(0, 255));
            dup = 1'b0;
            for (int j = 0; j < i; j++) if (bytes[j] == v) dup = 1'b1;
         end while (dup);
         bytes[i] = v;
      end
      push_q.delete();
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         push_q.push_back(bytes[i]);
         exp_q.push_back(bytes[i]);
      end
      acc_cnt = 0;
      fork
         push_seq(0);
         check_stream(0, 6);
         begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (acc_cnt < 5 && guard < 100) begin
               @(negedge clk);
               guard++;
            end
            checks++;
            if (acc_cnt != 5 || rdy_w[0] !== 1'b0) begin
               failures++;
               $display("FAIL fill_ready accepts=%0d tx_ready=%b expected accepts=5 tx_ready=0", acc_cnt, rdy_w[0]);
            end
         end
      join
   endtask

   task automatic test_parity();
      for (int k = 1; k <= 2; k++) begin
         push_q = '{8'h07};
         exp_q  = '{8'h07};
         fork
            push_seq(k);
            check_stream(k, 1);
         join
      end
   endtask

   task automatic test_stop_bits();
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      push_q = '{a, b};
      exp_q  = '{a, b};
      fork
         push_seq(3);
         check_stream(3, 2);
      join
   endtask

   task automatic test_reset_mid_frame();
      logic bad;
      push_q = '{8'h00, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      push_seq(0);
      // Into the middle of data bit 1 of the all-zero byte.
      repeat (2 * CPB + 200) @(negedge clk);
      checks++;
      if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset tx=%b busy=%b expected tx=0 busy=1", tx_w[0], busy_w[0]);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset tx=%b tx_ready=%b busy=%b expected 1 1 0", tx_w[0], rdy_w[0], busy_w[0]);
      end
      @(negedge clk);
      reset = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL post_reset_quiet tx=%b busy=%b expected line idle for 5000 cycles", tx_w[0], busy_w[0]);
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 4; k++) dat[k] = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_fill();
      test_parity();
      test_stop_bits();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
